// File: rtl/lsu_dmem.sv
// lsu_dmem: MEM-stage load/store unit with an internal byte-addressed RAM.
// Define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
module lsu_dmem #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0,
   parameter int RD_W        = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [2:0]      req_op_i,
   input  logic [31:0]     req_addr_i,
   input  logic [31:0]     req_wdata_i,
   input  logic [RD_W-1:0] req_rd_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [31:0]     resp_rdata_o,
   output logic [RD_W-1:0] resp_rd_o,
   output logic            resp_we_o,
   output logic            resp_err_o
);
   localparam int AW = $clog2(DEPTH_WORDS*4);
   localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS*4);
   localparam logic [3:0]  WLAST = 4'(WAIT_STATES-1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, err_q;
   logic [2:0]        op_q;
   logic [31:0]       addr_q, wdata_q, word_q;
   logic [RD_W-1:0]   rd_q;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              idle, commit, fault, rsvd, oor;
   logic              c_we;
   logic [2:0]        c_op;
   logic [1:0]        sz, lo;
   logic [31:0]       c_addr, c_wdata, wd, sh, ext;
   logic [3:0]        be;
   logic [AW-3:0]     widx;

   // In IDLE the request is taken straight from the ports so a
   // zero-wait access can commit on its accept edge.
   assign idle    = (state_q == S_IDLE);
   assign c_we    = idle ? req_we_i    : we_q;
   assign c_op    = idle ? req_op_i    : op_q;
   assign c_addr  = idle ? req_addr_i  : addr_q;
   assign c_wdata = idle ? req_wdata_i : wdata_q;
   assign sz      = c_op[1:0];
   assign widx    = c_addr[AW-1:2];
   assign rsvd    = (sz == 2'b11) || (c_op[2] && sz == 2'b10);
   assign oor     = (c_addr >= LIMIT);

`ifdef MISALIGN_TRAP_EN
   logic mis;
   assign mis   = (sz == 2'b01 && c_addr[0]) ||
                  (sz == 2'b10 && c_addr[1:0] != 2'b00);
   assign lo    = c_addr[1:0];
   assign fault = rsvd || oor || mis;
`else
   assign lo    = (sz == 2'b10) ? 2'b00 :
                  (sz == 2'b01) ? {c_addr[1], 1'b0} : c_addr[1:0];
   assign fault = rsvd || oor;
`endif

   always_comb begin
      be = 4'b0000;
      wd = c_wdata;
      unique case (1'b1)
         sz == 2'b00: begin
            be = 4'b0001 << lo;
            wd = {4{c_wdata[7:0]}};
         end
         sz == 2'b01: begin
            be = lo[1] ? 4'b1100 : 4'b0011;
            wd = {2{c_wdata[15:0]}};
         end
         sz == 2'b10: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == WLAST) begin
               cnt_d   = 4'd0;
               state_d = S_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: if (resp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         op_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (idle && req_valid_i) begin
            we_q    <= req_we_i;
            op_q    <= req_op_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_i;
         end
         if (commit) err_q <= fault;
      end
   end

   // RAM contents survive reset; only the commit edge touches them.
   always_ff @(posedge clk_i) begin
      if (commit) begin
         if (c_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem_q[widx][8*b +: 8] <= wd[8*b +: 8];
            end
         end
         word_q <= mem_q[widx];
      end
   end

   always_comb begin
      sh  = word_q >> {lo, 3'b000};
      ext = word_q;
      unique case (1'b1)
         sz == 2'b00: ext = {{24{~c_op[2] & sh[7]}}, sh[7:0]};
         sz == 2'b01: ext = {{16{~c_op[2] & sh[15]}}, sh[15:0]};
         default:     ext = word_q;
      endcase
   end

   assign req_ready_o  = idle;
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_we_o    = resp_valid_o && !we_q && !err_q;
   assign resp_err_o   = resp_valid_o && err_q;
   assign resp_rdata_o = resp_we_o ? ext : 32'd0;
   assign resp_rd_o    = resp_valid_o ? rd_q : '0;

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: scoreboard bench driving a zero-wait and a three-wait instance.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_dmem;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vi [2];
   logic        ri [2];
   logic        rdy [2];
   logic        pv [2];
   logic        pwe [2];
   logic        perr [2];
   logic [31:0] prd [2];
   logic [4:0]  prr [2];
   logic        we_s = 1'b0;
   logic [2:0]  op_s = 3'd0;
   logic [31:0] addr_s = 32'd0;
   logic [31:0] wd_s = 32'd0;
   logic [4:0]  rd_s = 5'd0;
   logic [4:0]  tag = 5'd1;

   typedef struct {
      logic [31:0] rdata;
      logic        we;
      logic        err;
      logic [4:0]  rd;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] mm [64];

   always #5 clk = ~clk;

   lsu_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .RD_W(5)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(vi[0]), .req_ready_o(rdy[0]),
      .req_we_i(we_s), .req_op_i(op_s), .req_addr_i(addr_s),
      .req_wdata_i(wd_s), .req_rd_i(rd_s),
      .resp_valid_o(pv[0]), .resp_ready_i(ri[0]),
      .resp_rdata_o(prd[0]), .resp_rd_o(prr[0]),
      .resp_we_o(pwe[0]), .resp_err_o(perr[0]));

   lsu_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .RD_W(5)) u_dut3 (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(vi[1]), .req_ready_o(rdy[1]),
      .req_we_i(we_s), .req_op_i(op_s), .req_addr_i(addr_s),
      .req_wdata_i(wd_s), .req_rd_i(rd_s),
      .resp_valid_o(pv[1]), .resp_ready_i(ri[1]),
      .resp_rdata_o(prd[1]), .resp_rd_o(prr[1]),
      .resp_we_o(pwe[1]), .resp_err_o(perr[1]));

   task automatic check(input string t, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", t, obs, exp);
   endtask

   task automatic xact(input int u, input bit w, input bit [2:0] o,
                       input bit [31:0] a, input bit [31:0] d,
                       input bit [31:0] er, input bit ee, input int hold);
      exp_t e;
      int lat;
      @(negedge clk);
      check("req_ready_idle", 32'(rdy[u]), 32'd1);
      we_s = w; op_s = o; addr_s = a; wd_s = d; rd_s = tag;
      vi[u] = 1'b1;
      e.rdata = (w || ee) ? 32'd0 : er;
      e.we    = !w && !ee;
      e.err   = ee;
      e.rd    = tag;
      sb.push_back(e);
      tag = tag + 5'd1;
      @(posedge clk);
      #1 vi[u] = 1'b0;
      @(negedge clk);
      lat = 1;
      while (!pv[u] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), (u == 0) ? 32'd1 : 32'd4);
      repeat (hold) begin
         check("hold_ready", 32'(rdy[u]), 32'd0);
         check("hold_valid", 32'(pv[u]), 32'd1);
         check("hold_rdata", prd[u], e.rdata);
         @(negedge clk);
      end
      e = sb.pop_front();
      check("rdata", prd[u], e.rdata);
      check("resp_we", 32'(pwe[u]), 32'(e.we));
      check("resp_err", 32'(perr[u]), 32'(e.err));
      check("resp_rd", 32'(prr[u]), 32'(e.rd));
      ri[u] = 1'b1;
      @(negedge clk);
      ri[u] = 1'b0;
      check("resp_drop", 32'(pv[u]), 32'd0);
   endtask

   function automatic logic [31:0] mload(input bit [2:0] o, input int off);
      logic [31:0] v;
      case (o[1:0])
         2'b00:   v = o[2] ? {24'd0, mm[off]} : {{24{mm[off][7]}}, mm[off]};
         2'b01:   v = o[2] ? {16'd0, mm[off+1], mm[off]}
                           : {{16{mm[off+1][7]}}, mm[off+1], mm[off]};
         default: v = {mm[off+3], mm[off+2], mm[off+1], mm[off]};
      endcase
      return v;
   endfunction

   task automatic mstore(input bit [1:0] s, input int off, input bit [31:0] d);
      for (int b = 0; b < (1 << s); b++) mm[off+b] = d[8*b +: 8];
   endtask

   initial begin
      bit [31:0] mis_exp;
      vi[0] = 1'b0; vi[1] = 1'b0; ri[0] = 1'b0; ri[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(rdy[0]), 32'd1);
      check("rst_valid", 32'(pv[1]), 32'd0);
      check("rst_rdata", prd[0], 32'd0);
      check("rst_we", 32'(pwe[0]), 32'd0);
      check("rst_err", 32'(perr[1]), 32'd0);
      check("rst_rd", 32'(prr[0]), 32'd0);
      rst_n = 1'b1;

      xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
      xact(0, 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 0);

      xact(0, 1, 3'b010, 32'h10, 32'h0, 0, 0, 0);
      xact(0, 1, 3'b000, 32'h11, 32'hFFFFFF80, 0, 0, 0);
      xact(0, 0, 3'b010, 32'h10, 0, 32'h00008000, 0, 0);
      xact(0, 0, 3'b000, 32'h11, 0, 32'hFFFFFF80, 0, 1);
      xact(0, 0, 3'b100, 32'h11, 0, 32'h00000080, 0, 0);

      xact(0, 1, 3'b010, 32'h20, 32'h44332211, 0, 0, 0);
      xact(0, 1, 3'b001, 32'h22, 32'h00008001, 0, 0, 0);
      xact(0, 0, 3'b001, 32'h22, 0, 32'hFFFF8001, 0, 0);
      xact(0, 0, 3'b101, 32'h22, 0, 32'h00008001, 0, 0);
      xact(0, 0, 3'b001, 32'h20, 0, 32'h00002211, 0, 0);
      xact(0, 0, 3'b010, 32'h20, 0, 32'h80012211, 0, 0);

      xact(1, 1, 3'b010, 32'h30, 32'hA5A55A5A, 0, 0, 2);
      xact(1, 0, 3'b010, 32'h30, 0, 32'hA5A55A5A, 0, 5);
      xact(1, 0, 3'b000, 32'h31, 0, 32'h0000005A, 0, 1);
      xact(1, 0, 3'b001, 32'h32, 0, 32'hFFFFA5A5, 0, 0);

      xact(0, 0, 3'b010, 32'd4096, 0, 0, 1, 0);
      xact(1, 1, 3'b010, 32'd4096, 32'h1, 0, 1, 0);
      xact(0, 0, 3'b011, 32'h10, 0, 0, 1, 0);
      xact(0, 0, 3'b110, 32'h10, 0, 0, 1, 0);
      xact(0, 0, 3'b010, 32'h10, 0, 32'h00008000, 0, 0);

      xact(0, 1, 3'b010, 32'h10, 32'h11111111, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
      xact(0, 1, 3'b010, 32'h13, 32'hCAFEF00D, 0, 1, 0);
      mis_exp = 32'h11111111;
      xact(0, 0, 3'b001, 32'h13, 0, 0, 1, 0);
`else
      xact(0, 1, 3'b010, 32'h13, 32'hCAFEF00D, 0, 0, 0);
      mis_exp = 32'hCAFEF00D;
      xact(0, 0, 3'b001, 32'h13, 0, 32'hFFFFCAFE, 0, 0);
`endif
      xact(0, 0, 3'b010, 32'h10, 0, mis_exp, 0, 0);

      xact(1, 1, 3'b010, 32'h40, 32'hA5A5A5A5, 0, 0, 0);
      @(negedge clk);
      we_s = 1'b1; op_s = 3'b010; addr_s = 32'h40;
      wd_s = 32'h12345678; rd_s = tag;
      vi[1] = 1'b1;
      @(posedge clk);
      #1 vi[1] = 1'b0;
      @(negedge clk);
      check("wait_ready", 32'(rdy[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(rdy[1]), 32'd1);
      check("midrst_valid", 32'(pv[1]), 32'd0);
      repeat (4) begin
         @(negedge clk);
         check("midrst_noresp", 32'(pv[1]), 32'd0);
      end
      rst_n = 1'b1;
      xact(1, 0, 3'b010, 32'h40, 0, 32'hA5A5A5A5, 0, 0);

      for (int i = 0; i < 16; i++) begin
         mstore(2'b10, 4*i, 32'h0);
         xact(0, 1, 3'b010, 32'h100 + 32'(4*i), 32'h0, 0, 0, 0);
      end
      for (int i = 0; i < 60; i++) begin
         bit w;
         bit [1:0] s;
         bit un;
         bit [2:0] o;
         int off;
         bit [31:0] d;
         w = 1'($urandom_range(1, 0));
         s = 2'($urandom_range(2, 0));
         un = (w || s == 2'b10) ? 1'b0 : 1'($urandom_range(1, 0));
         o = {un, s};
         off = $urandom_range(63, 0);
         off = off & ~((1 << s) - 1);
         d = $urandom;
         if (w) begin
            mstore(s, off, d);
            xact(0, 1, o, 32'h100 + 32'(off), d, 0, 0, 0);
         end else begin
            xact(0, 0, o, 32'h100 + 32'(off), 0, mload(o, off), 0,
                 $urandom_range(2, 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
